// File: rtl/spi_jtag_frame_decoder.sv
// Decodes a framed bitstream shifted through a JTAG USER1 data register into
// SPI flash transactions: start marker, LSB-first bit length, then payload.
module spi_jtag_frame_decoder #(
  parameter int unsigned LEN_W = 16
) (
  input  logic drck,
  input  logic rstn,
  input  logic sel,
  input  logic capture,
  input  logic shift,
  input  logic update,
  input  logic tdi,
  output logic tdo,
  output logic csn,
  output logic sck_en,
  output logic sdi_dq0,
  input  logic sdo_dq1,
  output logic wpn_dq2,
  output logic hldn_dq3,
  output logic busy,
  output logic xfer_done,
  output logic aborted
);

  localparam int unsigned CNT_W = $clog2(LEN_W + 1);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] HUNT = 3'd1;
  localparam logic [2:0] LEN  = 3'd2;
  localparam logic [2:0] XFER = 3'd3;
  localparam logic [2:0] TAIL = 3'd4;

  logic [2:0]       state, state_nxt;
  logic [LEN_W-1:0] len_reg, len_nxt;
  logic [LEN_W-1:0] remaining, remaining_nxt;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic             csn_nxt, sck_en_nxt, sdi_nxt, tdo_nxt;
  logic             busy_nxt, done_nxt, abort_nxt;

  assign wpn_dq2  = 1'b1;
  assign hldn_dq3 = 1'b1;

  // State and registered outputs
  always_ff @(posedge drck or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      len_reg   <= '0;
      remaining <= '0;
      bit_cnt   <= '0;
      csn       <= 1'b1;
      sck_en    <= 1'b0;
      sdi_dq0   <= 1'b0;
      tdo       <= 1'b0;
      busy      <= 1'b0;
      xfer_done <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      state     <= state_nxt;
      len_reg   <= len_nxt;
      remaining <= remaining_nxt;
      bit_cnt   <= bit_cnt_nxt;
      csn       <= csn_nxt;
      sck_en    <= sck_en_nxt;
      sdi_dq0   <= sdi_nxt;
      tdo       <= tdo_nxt;
      busy      <= busy_nxt;
      xfer_done <= done_nxt;
      aborted   <= abort_nxt;
    end
  end

  // Next-state and output decode; sel=0 freezes everything but sck_en
  always_comb begin
    state_nxt     = state;
    len_nxt       = len_reg;
    remaining_nxt = remaining;
    bit_cnt_nxt   = bit_cnt;
    csn_nxt       = csn;
    sck_en_nxt    = 1'b0;
    sdi_nxt       = sdi_dq0;
    tdo_nxt       = tdo;
    done_nxt      = 1'b0;
    abort_nxt     = 1'b0;

    if (sel) begin
      case (state)
        IDLE: begin
          tdo_nxt = 1'b0;
          if (capture) state_nxt = HUNT;
        end
        HUNT: begin
          tdo_nxt = 1'b0;
          if (update) begin
            state_nxt = IDLE;
            csn_nxt   = 1'b1;
          end else if (shift && tdi) begin
            state_nxt   = LEN;
            bit_cnt_nxt = '0;
            len_nxt     = '0;
          end
        end
        LEN: begin
          tdo_nxt = 1'b0;
          if (update) begin
            state_nxt = IDLE;
            csn_nxt   = 1'b1;
          end else if (shift) begin
            len_nxt     = (len_reg >> 1) | (LEN_W'(tdi) << (LEN_W - 1));
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(LEN_W - 1)) begin
              if (len_nxt != '0) begin
                state_nxt     = XFER;
                csn_nxt       = 1'b0;
                remaining_nxt = len_nxt;
              end else begin
                state_nxt = TAIL;
              end
            end
          end
        end
        XFER: begin
          if (update) begin
            state_nxt = IDLE;
            csn_nxt   = 1'b1;
            tdo_nxt   = 1'b0;
            abort_nxt = 1'b1;
          end else if (shift) begin
            sdi_nxt       = tdi;
            sck_en_nxt    = 1'b1;
            tdo_nxt       = sdo_dq1;
            remaining_nxt = remaining - LEN_W'(1);
            // Last payload bit closes the flash transaction on the same edge
            if (remaining == LEN_W'(1)) begin
              state_nxt = TAIL;
              csn_nxt   = 1'b1;
              done_nxt  = 1'b1;
            end
          end
        end
        TAIL: begin
          tdo_nxt = 1'b0;
          if (update) state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
          csn_nxt   = 1'b1;
          tdo_nxt   = 1'b0;
        end
      endcase
    end

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_spi_jtag_frame_decoder.sv
// Self-checking bench: random and directed frames compared at frame level
// against the expected payload, MISO echo and pulse counts.
module tb_spi_jtag_frame_decoder;

  localparam int unsigned LEN_W = 16;

  logic drck = 1'b0;
  logic rstn, sel, capture, shift, update, tdi, sdo_dq1;
  logic tdo, csn, sck_en, sdi_dq0, wpn_dq2, hldn_dq3, busy, xfer_done, aborted;

  int n_checks = 0;
  int n_fail   = 0;
  bit got_sdi[$];
  bit got_tdo[$];
  int n_done, n_abort;
  bit gap_en;

  always #5 drck = ~drck;

  spi_jtag_frame_decoder #(.LEN_W(LEN_W)) dut (
    .drck(drck), .rstn(rstn), .sel(sel), .capture(capture), .shift(shift),
    .update(update), .tdi(tdi), .tdo(tdo), .csn(csn), .sck_en(sck_en),
    .sdi_dq0(sdi_dq0), .sdo_dq1(sdo_dq1), .wpn_dq2(wpn_dq2), .hldn_dq3(hldn_dq3),
    .busy(busy), .xfer_done(xfer_done), .aborted(aborted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One drck cycle; outputs are observed 1 time unit after the rising edge
  task automatic step(input logic s, input logic c, input logic sh, input logic u,
                      input logic d, input logic m);
    sel = s; capture = c; shift = sh; update = u; tdi = d; sdo_dq1 = m;
    @(posedge drck);
    #1;
    if (sck_en) begin
      got_sdi.push_back(sdi_dq0);
      got_tdo.push_back(tdo);
    end
    if (xfer_done) n_done++;
    if (aborted) n_abort++;
  endtask

  task automatic maybe_gap(input bit force_sel0);
    if (force_sel0) begin
      repeat (4) begin
        step(1'b0, 1'($urandom), 1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
        check("sel0_sck_en", 32'(sck_en), 32'd0);
      end
    end else if (gap_en && $urandom_range(0, 3) == 0) begin
      if ($urandom_range(0, 1) == 1)
        step(1'b0, 1'($urandom), 1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
      else
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'($urandom), 1'($urandom));
      check("gap_sck_en", 32'(sck_en), 32'd0);
    end
  endtask

  task automatic run_frame(input int lead, input int len, input logic [31:0] mosi,
                           input logic [31:0] miso, input int abort_at, input int sel0_at);
    bit          was_aborted;
    int          exp_bits;
    logic [63:0] mask;
    logic [31:0] pk_sdi, pk_tdo;
    got_sdi.delete();
    got_tdo.delete();
    n_done = 0;
    n_abort = 0;
    was_aborted = (abort_at >= 0) && (abort_at < len);
    exp_bits = was_aborted ? abort_at : len;

    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("capture_busy", 32'(busy), 32'd1);
    for (int i = 0; i < lead; i++) begin
      maybe_gap(1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    maybe_gap(1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < int'(LEN_W); i++) begin
      maybe_gap(1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'(len >> i), 1'b0);
    end
    check("len_csn", 32'(csn), 32'(len == 0));

    for (int i = 0; i < len; i++) begin
      maybe_gap(i == sel0_at);
      if (i == abort_at) begin
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'($urandom), 1'b0);
        check("abort_csn", 32'(csn), 32'd1);
        check("abort_pulse", 32'(aborted), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        break;
      end
      step(1'b1, 1'b0, 1'b1, 1'b0, mosi[i], miso[i]);
    end

    if (!was_aborted) begin
      if (len > 0) begin
        check("last_csn", 32'(csn), 32'd1);
        check("last_done", 32'(xfer_done), 32'd1);
      end
      repeat (2) step(1'b1, 1'b0, 1'b1, 1'b0, 1'($urandom), 1'($urandom));
      check("tail_busy", 32'(busy), 32'd1);
      check("tail_csn", 32'(csn), 32'd1);
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("end_busy", 32'(busy), 32'd0);
    end

    mask = (64'd1 << exp_bits) - 64'd1;
    pk_sdi = '0;
    pk_tdo = '0;
    foreach (got_sdi[i]) if (i < 32) pk_sdi[i] = got_sdi[i];
    foreach (got_tdo[i]) if (i < 32) pk_tdo[i] = got_tdo[i];
    check("sck_count", 32'(got_sdi.size()), 32'(exp_bits));
    check("sdi_bits", pk_sdi, 32'(64'(mosi) & mask));
    check("tdo_bits", pk_tdo, 32'(64'(miso) & mask));
    check("done_count", 32'(n_done), 32'(!was_aborted && len > 0));
    check("abort_count", 32'(n_abort), 32'(was_aborted));
    check("idle_tdo", 32'(tdo), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int len, ab;
    rstn = 1'b0; sel = 1'b0; capture = 1'b0; shift = 1'b0; update = 1'b0;
    tdi = 1'b0; sdo_dq1 = 1'b0; gap_en = 1'b0;
    repeat (2) @(posedge drck);
    #1;
    check("rst_csn", 32'(csn), 32'd1);
    check("rst_sck_en", 32'(sck_en), 32'd0);
    check("rst_sdi", 32'(sdi_dq0), 32'd0);
    check("rst_tdo", 32'(tdo), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pulses", 32'({xfer_done, aborted}), 32'd0);
    check("tied_wp_hold", 32'({wpn_dq2, hldn_dq3}), 32'd3);
    rstn = 1'b1;

    // Idle ignores shifting without a prior capture
    repeat (3) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("idle_no_capture", 32'(busy), 32'd0);

    run_frame(3, 8, 32'hA5, 32'h0, -1, -1);
    run_frame(0, 0, 32'h0, 32'h0, -1, -1);
    run_frame(2, 16, $urandom, $urandom, 5, -1);
    run_frame(1, 8, 32'h5A, 32'hC3, -1, 3);
    run_frame(0, 8, 32'h96, 32'h3C, -1, -1);

    // Asynchronous reset in the middle of a payload
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < int'(LEN_W); i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'(8 >> i), 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    check("pre_rst_csn", 32'(csn), 32'd0);
    #1 rstn = 1'b0;
    #1;
    check("async_rst_csn", 32'(csn), 32'd1);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_sck_en", 32'(sck_en), 32'd0);
    #1 rstn = 1'b1;
    repeat (LEN_W + 4) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("post_rst_idle_busy", 32'(busy), 32'd0);
    check("post_rst_idle_csn", 32'(csn), 32'd1);

    gap_en = 1'b1;
    repeat (20) begin
      len = $urandom_range(0, 32);
      ab = (len > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      run_frame($urandom_range(0, 4), len, $urandom, $urandom, ab, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_jtag_frame_decoder.md
SPI_JTAG_FRAME_DECODER -- requirements
Module: spi_jtag_frame_decoder

Interface
REQ-001 Parameter: LEN_W, default 16, width of the payload bit-length field.
REQ-002 drck  in  1  clock: gated JTAG DR clock from the USER1 BSCAN primitive; all state updates on rising edge.
REQ-003 rstn  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 sel  in  1  USER1 instruction active.
REQ-005 capture  in  1  TAP in Capture-DR.
REQ-006 shift  in  1  TAP in Shift-DR.
REQ-007 update  in  1  TAP in Update-DR.
REQ-008 tdi  in  1  serial data from TAP.
REQ-009 tdo  out  1  serial data to TAP.
REQ-010 csn  out  1  flash chip select, active-low, registered.
REQ-011 sck_en  out  1  flash clock qualifier; the parent gates drck with it to form sck.
REQ-012 sdi_dq0  out  1  flash MOSI, registered.
REQ-013 sdo_dq1  in  1  flash MISO.
REQ-014 wpn_dq2, hldn_dq3  out  1 each  tied 1.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 xfer_done  out  1  one-cycle pulse when the last payload bit is consumed.
REQ-017 aborted  out  1  one-cycle pulse when update ends a frame during XFER.

Function
REQ-018 States: IDLE, HUNT, LEN, XFER, TAIL; a "qualified bit" is any cycle with sel=1 and shift=1.
REQ-019 IDLE: capture=1 and sel=1 -> HUNT; all other inputs ignored.
REQ-020 HUNT: qualified bit with tdi=1 (start marker) -> LEN and bit counter cleared; tdi=0 stays in HUNT.
REQ-021 LEN: each qualified bit shifts tdi into len_reg LSB-first; after exactly LEN_W bits -> XFER if len_reg != 0, else -> TAIL with csn left high.
REQ-022 Entry to XFER drives csn to 0 on the same edge; remaining counter is loaded with len_reg.
REQ-023 XFER: each qualified bit registers sdi_dq0<=tdi, asserts sck_en for that cycle, and decrements remaining.
REQ-024 XFER: non-qualified cycles deassert sck_en and hold sdi_dq0, remaining and csn.
REQ-025 XFER: the qualified bit taken with remaining=1 -> TAIL, csn<=1 and xfer_done=1 on the same edge.
REQ-026 tdo is registered: in XFER it carries sdo_dq1 sampled on each qualified bit, so the host sees MISO one bit late; in every other state it is 0.
REQ-027 TAIL: update=1 and sel=1 -> IDLE; qualified bits are ignored.
REQ-028 update=1 with sel=1 in HUNT, LEN or XFER -> IDLE with csn<=1 and sck_en<=0.
REQ-029 REQ-028 taken from XFER pulses aborted=1; no xfer_done pulse in that case.
REQ-030 update has priority over a coincident qualified bit; the bit is discarded.
REQ-031 sel=0 freezes all state except sck_en, which is 0.
REQ-032 Maximum payload is 2^LEN_W-1 bits; the counter does not wrap.
REQ-033 Latency: csn falls on the edge that consumes the last length bit; the first payload bit reaches sdi_dq0 one edge later.

Reset
REQ-034 rstn=0 asynchronously forces: state=IDLE, csn=1, sck_en=0, sdi_dq0=0, tdo=0, busy=0, xfer_done=0, aborted=0, len_reg=0, remaining=0.
REQ-035 rstn deasserted mid-frame resumes in IDLE; the next frame requires a new capture.

Verification
REQ-036 Capture, shift 3 zeros, then 1, then len=8 LSB-first, then payload 0xA5 -> csn low for exactly 8 sck_en cycles, sdi_dq0 sequence 1,0,1,0,0,1,0,1, one xfer_done, csn=1 afterwards.
REQ-037 len=0 frame -> csn never falls, sck_en never asserts, state reaches TAIL, then update returns to IDLE.
REQ-038 len=16 frame with update after 5 payload bits -> csn=1 and aborted=1 on that edge, no xfer_done, state=IDLE.
REQ-039 sel=0 for 4 cycles during XFER with shift=1 -> no sck_en, remaining unchanged, transfer completes correctly after sel returns.
REQ-040 sdo_dq1 driven with 0x3C during an 8-bit payload -> tdo returns the same bits delayed by one qualified bit.
REQ-041 rstn pulsed low during XFER -> csn=1 immediately without waiting for a clock; busy=0.
